// File: rtl/aw_rr_arbiter.sv
// Round-robin arbiter for the AXI write-address channel. It grants one master,
// forwards its AW beat, then holds the W channel for that master until WLAST.
module aw_rr_arbiter #(
  parameter  int NUM_M     = 2,
  parameter  int ID_BITS   = 4,
  parameter  int ADDR_BITS = 32,
  parameter  int LEN_BITS  = 4,
  localparam int SEL_W     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M*ID_BITS-1:0]   AWID_M,
  input  logic [NUM_M*ADDR_BITS-1:0] AWADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]  AWLEN_M,
  input  logic [NUM_M*3-1:0]         AWSIZE_M,
  input  logic [NUM_M*2-1:0]         AWBURST_M,
  input  logic [NUM_M-1:0]           AWVALID_M,
  output logic [NUM_M-1:0]           AWREADY_M,
  output logic [ID_BITS+3:0]         AWID_S,
  output logic [ADDR_BITS-1:0]       AWADDR_S,
  output logic [LEN_BITS-1:0]        AWLEN_S,
  output logic [2:0]                 AWSIZE_S,
  output logic [1:0]                 AWBURST_S,
  output logic                       AWVALID_S,
  input  logic                       AWREADY_S,
  input  logic                       WVALID,
  input  logic                       WREADY,
  input  logic                       WLAST,
  output logic [SEL_W-1:0]           W_SEL,
  output logic                       AW_IDLE,
  output logic                       AW_LOCK,
  output logic                       LEN_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_LOCK
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     last_grant_q, last_grant_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 len_err_q, len_err_d;

  logic [ID_BITS-1:0]   id_m    [NUM_M];
  logic [ADDR_BITS-1:0] addr_m  [NUM_M];
  logic [LEN_BITS-1:0]  len_m   [NUM_M];
  logic [2:0]           size_m  [NUM_M];
  logic [1:0]           burst_m [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign id_m[i]    = AWID_M[i*ID_BITS +: ID_BITS];
    assign addr_m[i]  = AWADDR_M[i*ADDR_BITS +: ADDR_BITS];
    assign len_m[i]   = AWLEN_M[i*LEN_BITS +: LEN_BITS];
    assign size_m[i]  = AWSIZE_M[i*3 +: 3];
    assign burst_m[i] = AWBURST_M[i*2 +: 2];
  end

  logic             w_beat;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] cand;
  logic             found;

  assign w_beat = WVALID & WREADY;

  // Search starts one past the last accepted grant, so every waiting master
  // is reached within NUM_M grants.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    winner = last_grant_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = SEL_W'((int'(last_grant_q) + k) % NUM_M);
      if (!found && AWVALID_M[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    len_err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|AWVALID_M) begin
          sel_d   = winner;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (AWVALID_M[sel_q] && AWREADY_S) begin
          addr_d       = addr_m[sel_q];
          cnt_d        = len_m[sel_q];
          last_grant_d = sel_q;
          state_d      = S_LOCK;
        end else if (!AWVALID_M[sel_q]) begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (w_beat) begin
          // Mismatch flag is informational only; WLAST always ends the burst.
          len_err_d = WLAST ? (cnt_q != '0) : (cnt_q == '0);
          if (WLAST) begin
            state_d = S_IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_BITS'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      last_grant_q <= SEL_W'(NUM_M - 1);
      cnt_q        <= '0;
      addr_q       <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      len_err_q    <= len_err_d;
    end
  end

  always_comb begin
    AWREADY_M = '0;
    AWVALID_S = 1'b0;
    AWID_S    = '0;
    AWADDR_S  = addr_q;
    AWLEN_S   = '0;
    AWSIZE_S  = '0;
    AWBURST_S = '0;
    if (state_q == S_GRANT) begin
      AWVALID_S        = AWVALID_M[sel_q];
      AWREADY_M[sel_q] = AWREADY_S;
      AWID_S           = {4'(sel_q), id_m[sel_q]};
      AWADDR_S         = addr_m[sel_q];
      AWLEN_S          = len_m[sel_q];
      AWSIZE_S         = size_m[sel_q];
      AWBURST_S        = burst_m[sel_q];
    end
  end

  assign W_SEL   = sel_q;
  assign AW_IDLE = (state_q == S_IDLE);
  assign AW_LOCK = (state_q == S_LOCK);
  assign LEN_ERR = len_err_q;

endmodule

// File: tb/tb_aw_rr_arbiter.sv
// Self-checking bench for aw_rr_arbiter (4 masters): directed cycle table,
// round-robin order sequence, and randomized traffic against a reference model.
module tb_aw_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  awid_m;
  logic [127:0] awaddr_m;
  logic [15:0]  awlen_m;
  logic [11:0]  awsize_m;
  logic [7:0]   awburst_m;
  logic [3:0]   awvalid_m;
  logic [3:0]   awready_m;
  logic [7:0]   awid_s;
  logic [31:0]  awaddr_s;
  logic [3:0]   awlen_s;
  logic [2:0]   awsize_s;
  logic [1:0]   awburst_s;
  logic         awvalid_s, awready_s, wvalid, wready, wlast;
  logic [1:0]   w_sel;
  logic         aw_idle, aw_lock, len_err;

  aw_rr_arbiter #(.NUM_M(4), .ID_BITS(4), .ADDR_BITS(32), .LEN_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .AWID_M(awid_m), .AWADDR_M(awaddr_m), .AWLEN_M(awlen_m), .AWSIZE_M(awsize_m),
    .AWBURST_M(awburst_m), .AWVALID_M(awvalid_m), .AWREADY_M(awready_m),
    .AWID_S(awid_s), .AWADDR_S(awaddr_s), .AWLEN_S(awlen_s), .AWSIZE_S(awsize_s),
    .AWBURST_S(awburst_s), .AWVALID_S(awvalid_s), .AWREADY_S(awready_s),
    .WVALID(wvalid), .WREADY(wready), .WLAST(wlast),
    .W_SEL(w_sel), .AW_IDLE(aw_idle), .AW_LOCK(aw_lock), .LEN_ERR(len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs move 1 time unit after the rising edge; outputs are sampled 4 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] av;
    logic       ar;
    logic       wv;
    logic       wl;
    logic       idle;
    logic       lock;
    logic       avs;
    logic [3:0] arm;
    logic [1:0] wsel;
    logic [7:0] awid;
    logic       lerr;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [3:0] av, input logic ar,
                             input logic wv, input logic wl, input logic idle,
                             input logic lock, input logic avs, input logic [3:0] arm,
                             input logic [1:0] wsel, input logic [7:0] awid,
                             input logic lerr);
    vec_t t;
    t.rst = r; t.av = av; t.ar = ar; t.wv = wv; t.wl = wl;
    t.idle = idle; t.lock = lock; t.avs = avs; t.arm = arm;
    t.wsel = wsel; t.awid = awid; t.lerr = lerr;
    return t;
  endfunction

  // Reference model state: "pending" = a grant is offered, "locked" = W burst owned.
  bit          m_pending, m_locked, m_err;
  int          m_sel, m_last, m_left;
  logic [31:0] m_addr;

  task automatic model_reset();
    m_pending = 0; m_locked = 0; m_err = 0;
    m_sel = 0; m_last = 3; m_left = 0; m_addr = '0;
  endtask

  task automatic model_expect(output logic [63:0] e);
    logic       e_avs;
    logic [3:0] e_arm;
    logic [7:0] e_id;
    logic [31:0] e_addr;
    logic [3:0] e_len;
    logic [2:0] e_size;
    logic [1:0] e_burst;
    e_avs = 0; e_arm = '0; e_id = '0; e_addr = m_addr; e_len = '0; e_size = '0; e_burst = '0;
    if (m_pending) begin
      e_avs   = awvalid_m[m_sel];
      e_arm   = 4'(awready_s) << m_sel;
      e_id    = {4'(m_sel), awid_m[m_sel*4 +: 4]};
      e_addr  = awaddr_m[m_sel*32 +: 32];
      e_len   = awlen_m[m_sel*4 +: 4];
      e_size  = awsize_m[m_sel*3 +: 3];
      e_burst = awburst_m[m_sel*2 +: 2];
    end
    e = 64'({e_avs, e_arm, e_id, e_addr, e_len, e_size, e_burst, 2'(m_sel),
             !m_pending && !m_locked, m_locked, m_err});
  endtask

  task automatic model_step();
    bit beat, err_n;
    beat  = wvalid && wready;
    err_n = m_locked && beat && (wlast ? (m_left != 0) : (m_left == 0));
    if (rst) begin
      model_reset();
    end else begin
      if (!m_pending && !m_locked) begin
        if (awvalid_m != 0) begin
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (awvalid_m[c] && !m_pending) begin
              m_sel = c;
              m_pending = 1;
            end
          end
        end
      end else if (m_pending) begin
        if (awvalid_m[m_sel] && awready_s) begin
          m_addr    = awaddr_m[m_sel*32 +: 32];
          m_left    = int'(awlen_m[m_sel*4 +: 4]);
          m_last    = m_sel;
          m_pending = 0;
          m_locked  = 1;
        end else if (!awvalid_m[m_sel]) begin
          m_pending = 0;
        end
      end else if (beat) begin
        if (wlast) m_locked = 0;
        else if (m_left > 0) m_left--;
      end
      m_err = err_n;
    end
  endtask

  function automatic logic [63:0] dut_outs();
    return 64'({awvalid_s, awready_m, awid_s, awaddr_s, awlen_s, awsize_s, awburst_s,
                w_sel, aw_idle, aw_lock, len_err});
  endfunction

  vec_t        vecs[25];
  logic [3:0]  grants[$];
  logic [3:0]  rr_exp[4];
  logic [63:0] exp_v;

  initial begin
    rst = 1'b1; awvalid_m = '0; awready_s = 1'b0;
    wvalid = 1'b0; wready = 1'b1; wlast = 1'b0;
    awid_m    = {4'h8, 4'h7, 4'h6, 4'h5};
    awaddr_m  = {32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
    awlen_m   = {4'd3, 4'd3, 4'd3, 4'd3};
    awsize_m  = {3'd2, 3'd2, 3'd2, 3'd2};
    awburst_m = {2'd1, 2'd1, 2'd1, 2'd1};

    //               rst   av       ar    wv    wl  | idle  lock  avs   arm      wsel   awid    lerr
    vecs[0]  = v(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[1]  = v(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[2]  = v(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 8'h05, 1'b0);
    vecs[3]  = v(1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 8'h05, 1'b0);
    vecs[4]  = v(1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[5]  = v(1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[6]  = v(1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[7]  = v(1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[8]  = v(1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[9]  = v(1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 8'h16, 1'b0);
    vecs[10] = v(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h00, 1'b0);
    vecs[11] = v(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h00, 1'b0);
    vecs[12] = v(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00, 1'b1);
    vecs[13] = v(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00, 1'b0);
    vecs[14] = v(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00, 1'b0);
    vecs[15] = v(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h27, 1'b0);
    vecs[16] = v(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00, 1'b0);
    vecs[17] = v(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 2'd2, 8'h27, 1'b0);
    vecs[18] = v(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h00, 1'b0);
    vecs[19] = v(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h00, 1'b0);
    vecs[20] = v(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[21] = v(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);
    vecs[22] = v(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 8'h05, 1'b0);
    vecs[23] = v(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h05, 1'b0);
    vecs[24] = v(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0);

    repeat (3) next_cycle();

    for (int i = 0; i < 25; i++) begin
      rst = vecs[i].rst; awvalid_m = vecs[i].av; awready_s = vecs[i].ar;
      wvalid = vecs[i].wv; wlast = vecs[i].wl;
      #4;
      check($sformatf("vec%0d", i),
            64'({aw_idle, aw_lock, awvalid_s, awready_m, w_sel, awid_s, len_err}),
            64'({vecs[i].idle, vecs[i].lock, vecs[i].avs, vecs[i].arm, vecs[i].wsel,
                 vecs[i].awid, vecs[i].lerr}));
      if (i == 4 || i == 10) check($sformatf("lock_addr%0d", i), 64'(awaddr_s),
                                   (i == 4) ? 64'h1000_0000 : 64'h1000_0100);
      next_cycle();
    end

    // Masters 1 and 3 held valid: grants must alternate starting with master 1.
    rst = 1'b1; awvalid_m = '0; wvalid = 1'b0; wlast = 1'b0;
    next_cycle();
    rst = 1'b0; awvalid_m = 4'b1010; awready_s = 1'b1; wvalid = 1'b1; wlast = 1'b1;
    rr_exp = '{4'd1, 4'd3, 4'd1, 4'd3};
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #4;
      if (awvalid_s && awready_s) grants.push_back(awid_s[7:4]);
      next_cycle();
    end
    check("rr_grant_count", 64'(grants.size()), 64'd4);
    for (int k = 0; k < grants.size(); k++)
      check($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(rr_exp[k]));

    // Randomized traffic against the reference model.
    rst = 1'b1; awvalid_m = '0; wvalid = 1'b0; wlast = 1'b0;
    model_reset();
    next_cycle();
    rst = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      awvalid_m = 4'($urandom);
      awready_s = 1'($urandom);
      wvalid    = 1'($urandom);
      wready    = ($urandom_range(0, 3) != 0);
      wlast     = ($urandom_range(0, 3) == 0);
      for (int m = 0; m < 4; m++) begin
        awid_m[m*4 +: 4]     = 4'($urandom);
        awaddr_m[m*32 +: 32] = $urandom;
        awlen_m[m*4 +: 4]    = 4'($urandom_range(0, 4));
        awsize_m[m*3 +: 3]   = 3'($urandom);
        awburst_m[m*2 +: 2]  = 2'($urandom);
      end
      #4;
      model_expect(exp_v);
      check($sformatf("rand%0d", n), dut_outs(), exp_v);
      model_step();
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
